// File: rtl/drc_frame_sched_pkg.sv
// Shared definitions for the drc_frame_sched frame sequencer: state encoding
// and default widths.
package drc_frame_sched_pkg;

  localparam int DEF_I_PXL_W = 16;
  localparam int DEF_H_CNT_W = 12;
  localparam int DEF_V_CNT_W = 12;
  localparam int DEF_FCNT_W  = 16;

  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WAIT_FS = 3'd1;
  localparam state_t ST_ACTIVE  = 3'd2;
  localparam state_t ST_PAD     = 3'd3;
  localparam state_t ST_DISCARD = 3'd4;

endpackage

// File: rtl/drc_xy_counter.sv
// Column/row pixel position counter with end-of-frame compare. It is shared by
// real pixels and padding pixels.
module drc_xy_counter #(
  parameter int H_CNT_W = 12,
  parameter int V_CNT_W = 12
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               i_clr,
  input  logic               i_adv,
  input  logic [H_CNT_W-1:0] i_width,
  input  logic [V_CNT_W-1:0] i_height,
  output logic               o_at_last
);

  localparam logic [H_CNT_W-1:0] X_ONE = H_CNT_W'(1);
  localparam logic [V_CNT_W-1:0] Y_ONE = V_CNT_W'(1);

  logic [H_CNT_W-1:0] r_x;
  logic [V_CNT_W-1:0] r_y;
  logic               w_x_end;
  logic               w_y_end;

  assign w_x_end   = (r_x == (i_width - X_ONE));
  assign w_y_end   = (r_y == (i_height - Y_ONE));
  assign o_at_last = w_x_end & w_y_end;

  // The row counter wraps with the last pixel, so the next frame starts clean
  // even before its explicit clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : (r_y + Y_ONE);
      end else begin
        r_x <= r_x + X_ONE;
      end
    end
  end

endmodule

// File: rtl/drc_frame_sched.sv
// Frame sequencer between DVP capture and the AXIS aligner. It emits whole
// frames of exactly width*height pixels. The macro DRC_FRAME_STAT_EN builds
// the frame and error counters.
//
// state   | meaning
// IDLE    | disarmed, waiting for a valid cfg_start
// WAIT_FS | armed, dropping pixels until s_vsync
// ACTIVE  | forwarding input pixels to the aligner
// PAD     | frame ended short, emitting zero pixels up to the frame size
// DISCARD | frame done; either re-arm (continuous) or return to IDLE
module drc_frame_sched
  import drc_frame_sched_pkg::*;
#(
  parameter int I_PXL_W = DEF_I_PXL_W,
  parameter int H_CNT_W = DEF_H_CNT_W,
  parameter int V_CNT_W = DEF_V_CNT_W,
  parameter int FCNT_W  = DEF_FCNT_W
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic               cfg_cont,
  input  logic [H_CNT_W-1:0] cfg_width,
  input  logic [V_CNT_W-1:0] cfg_height,
  input  logic               s_vsync,
  input  logic [I_PXL_W-1:0] s_pxl_dat,
  input  logic               s_pxl_vld,
  output logic [I_PXL_W-1:0] m_pxl_dat,
  output logic               m_pxl_vld,
  output logic               m_pxl_last,
  input  logic               m_pxl_rdy,
  output logic               sts_busy,
  output logic               sts_done,
  output logic               sts_ovf,
  output logic [FCNT_W-1:0]  sts_frame_cnt,
  output logic [FCNT_W-1:0]  sts_ovf_cnt
);

  state_t             r_state;
  state_t             w_nxt_state;
  logic [H_CNT_W-1:0] r_width;
  logic [V_CNT_W-1:0] r_height;
  logic               r_cont;
  logic               r_stop_pend;
  logic               r_ovf;
  logic               r_done;

  logic               w_start_ok;
  logic               w_at_last;
  logic               w_hs;
  logic               w_last_hs;
  logic               w_lost;
  logic               w_early;
  logic               w_cnt_clr;

  assign w_start_ok = cfg_start && (cfg_width != '0) && (cfg_height != '0);
  assign w_hs       = m_pxl_vld & m_pxl_rdy;
  assign w_last_hs  = w_hs & w_at_last;
  assign w_lost     = (r_state == ST_ACTIVE) & s_pxl_vld & ~m_pxl_rdy;
  // A vsync that coincides with the last handshake ends the frame normally.
  assign w_early    = (r_state == ST_ACTIVE) & s_vsync & ~w_last_hs;
  assign w_cnt_clr  = (w_nxt_state == ST_ACTIVE) && (r_state != ST_ACTIVE);

  drc_xy_counter #(
    .H_CNT_W (H_CNT_W),
    .V_CNT_W (V_CNT_W)
  ) u_xy (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_clr     (w_cnt_clr),
    .i_adv     (w_hs),
    .i_width   (r_width),
    .i_height  (r_height),
    .o_at_last (w_at_last)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_nxt_state = ST_WAIT_FS;
      end
      ST_WAIT_FS: begin
        if (cfg_stop || r_stop_pend) w_nxt_state = ST_IDLE;
        else if (s_vsync)            w_nxt_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_last_hs)    w_nxt_state = ST_DISCARD;
        else if (s_vsync) w_nxt_state = ST_PAD;
      end
      ST_PAD: begin
        if (w_last_hs) w_nxt_state = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (!r_cont || r_stop_pend || cfg_stop) w_nxt_state = ST_IDLE;
        else if (s_vsync)                       w_nxt_state = ST_ACTIVE;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    m_pxl_dat = '0;
    m_pxl_vld = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        m_pxl_dat = s_pxl_dat;
        m_pxl_vld = s_pxl_vld;
      end
      ST_PAD: begin
        m_pxl_vld = 1'b1;
      end
      default: ;
    endcase
    m_pxl_last = m_pxl_vld & w_at_last;
    sts_busy   = (r_state != ST_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_width     <= '0;
      r_height    <= '0;
      r_cont      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_last_hs;
      if (r_state == ST_IDLE) begin
        // A stop that arrives together with an accepted start stays pending.
        r_stop_pend <= w_start_ok & cfg_stop;
        if (w_start_ok) begin
          r_width  <= cfg_width;
          r_height <= cfg_height;
          r_cont   <= cfg_cont;
          r_ovf    <= 1'b0;
        end
      end else begin
        if (w_nxt_state == ST_IDLE) r_stop_pend <= 1'b0;
        else if (cfg_stop)          r_stop_pend <= 1'b1;
        if (w_lost || w_early)      r_ovf       <= 1'b1;
      end
    end
  end

  assign sts_done = r_done;
  assign sts_ovf  = r_ovf;

`ifdef DRC_FRAME_STAT_EN
  logic              r_frm_err;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic [FCNT_W-1:0] r_ovf_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frm_err   <= 1'b0;
      r_frame_cnt <= '0;
      r_ovf_cnt   <= '0;
    end else begin
      if (w_cnt_clr)              r_frm_err <= 1'b0;
      else if (w_lost || w_early) r_frm_err <= 1'b1;
      // A pixel cannot be lost on the last handshake, so the registered flag is complete here.
      if (w_last_hs) begin
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
        if (r_frm_err) r_ovf_cnt <= r_ovf_cnt + FCNT_W'(1);
      end
    end
  end

  assign sts_frame_cnt = r_frame_cnt;
  assign sts_ovf_cnt   = r_ovf_cnt;
`else
  assign sts_frame_cnt = '0;
  assign sts_ovf_cnt   = '0;
`endif

endmodule
